// File: rtl/uart_rx_cfg.sv
// UART receiver: 2-flop synchroniser, 3-sample majority vote, parity/stop checks, valid/ready output.
// Define UART_RX_CMD_EN to add the ASCII command decoder that drives the work/enc outputs.
module uart_rx_cfg #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int UART_BPS    = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_CMD_EN
    ,
    output logic                 work,
    output logic                 enc
`endif
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;
    localparam int CW      = $clog2(BPS_CNT);
    localparam int IW      = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] SAMP_A   = CW'(HALF - 1);
    localparam logic [CW-1:0] SAMP_B   = CW'(HALF);
    localparam logic [CW-1:0] SAMP_C   = CW'(HALF + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_next;
    logic                 rx_meta, rxs;
    logic [CW-1:0]        bit_cnt;
    logic                 samp_a, samp_b;
    logic                 bit_val, resolve, wrap;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IW-1:0]        data_idx;
    logic                 stop_idx;
    logic                 stop_low, parity_bad;
    logic                 frame_done, frame_bad, word_good, load;

    assign resolve    = (bit_cnt == SAMP_C);
    assign wrap       = (bit_cnt == CNT_LAST);
    assign bit_val    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign frame_done = (state == STOP) && resolve && (stop_idx == 1'(STOP_BITS - 1));
    assign frame_bad  = stop_low | ~bit_val;
    assign word_good  = frame_done && !frame_bad && !parity_bad;
    assign load       = word_good && (!rx_valid || rx_ready);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // The last stop bit leaves at its resolve point rather than the wrap, absorbing baud mismatch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (!rxs) state_next = START;
            START: begin
                if (resolve && bit_val) state_next = IDLE;
                else if (wrap)          state_next = DATA;
            end
            DATA:   if (wrap && data_idx == IW'(DATA_BITS - 1))
                        state_next = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY: if (wrap) state_next = STOP;
            STOP:   if (frame_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   bit_cnt <= '0;
        else if (state == IDLE || state_next == IDLE) bit_cnt <= '0;
        else if (wrap)                                bit_cnt <= '0;
        else                                          bit_cnt <= bit_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (bit_cnt == SAMP_A) samp_a <= rxs;
            if (bit_cnt == SAMP_B) samp_b <= rxs;
        end
    end

    // Bits arrive LSB first, so each one enters at the top and moves down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            data_idx   <= '0;
            stop_idx   <= 1'b0;
            stop_low   <= 1'b0;
            parity_bad <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_idx   <= '0;
                    stop_idx   <= 1'b0;
                    stop_low   <= 1'b0;
                    parity_bad <= 1'b0;
                end
                DATA: begin
                    if (resolve) shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                    if (wrap)    data_idx  <= data_idx + IW'(1);
                end
                PARITY: if (resolve)
                    parity_bad <= (PARITY_MODE == 1) ? ~(^shift_reg ^ bit_val)
                                                     :  (^shift_reg ^ bit_val);
                STOP: begin
                    if (resolve && !bit_val) stop_low <= 1'b1;
                    if (wrap)                stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_done && frame_bad;
            parity_err <= frame_done && !frame_bad && parity_bad;
            overrun    <= word_good && rx_valid && !rx_ready;
            if (load) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_CMD_EN
    logic [7:0] cmd_byte;
    assign cmd_byte = 8'(shift_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= 1'b0;
            enc  <= 1'b1;
        end else if (load) begin
            case (cmd_byte)
                8'h57:   work <= 1'b1;
                8'h53:   work <= 1'b0;
                8'h45:   enc  <= 1'b1;
                8'h44:   enc  <= 1'b0;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver for the verify platform. It supports configurable data width, parity and stop bits, uses a 2-flop input synchroniser and 3-sample majority voting, and rejects false start bits. Each received word is delivered on a valid/ready handshake, with parity, framing and overrun error reporting. An optional command decoder drives the AES core's work/enc controls from received ASCII characters.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS clocks per bit, must be >= 8
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY_MODE, 0, parity setting: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
uart_rxd  input  1  serial line, asynchronous to clk, idles high
rx_data  output  DATA_BITS  received word, LSB is the first bit received
rx_valid  output  1  rx_data holds an unconsumed word
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready
parity_err  output  1  one-cycle pulse: parity mismatch, word dropped
frame_err  output  1  one-cycle pulse: a stop bit sampled low, word dropped
overrun  output  1  one-cycle pulse: good word arrived while rx_valid && !rx_ready, new word dropped
busy  output  1  high whenever the FSM is not in IDLE
work  output  1  present only with UART_RX_CMD_EN; AES run enable
enc  output  1  present only with UART_RX_CMD_EN; 1 = encrypt, 0 = decrypt

Behaviour:
- Reset: rx_data=0, rx_valid=0, all error pulses=0, busy=0, FSM=IDLE, synchroniser flops=1, work=0, enc=1.
- uart_rxd passes through 2 flops to form rxs. All decisions use rxs.
- Bit timer: bit_cnt counts 0..BPS_CNT-1 and wraps, so each bit lasts exactly BPS_CNT clocks. It is held at 0 in IDLE.
- Sampling: H = BPS_CNT/2. rxs is sampled at bit_cnt = H-1, H and H+1. The bit value is the majority of the 3 samples and is resolved at bit_cnt = H+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rxs == 0 -> START, with bit_cnt starting at 0 on the next clock.
  - START: if the resolved value is 1, this is a false start -> IDLE (no pulse). Otherwise go to DATA at the bit_cnt wrap.
  - DATA: shift DATA_BITS bits LSB-first into a shift register. After the last bit, go to PARITY if PARITY_MODE != 0, else to STOP.
  - PARITY: compare the received bit against the computed parity. Odd mode: the XOR of data and parity bits must be 1. Even mode: it must be 0. Latch the result, then go to STOP.
  - STOP: resolve each stop bit. After the final stop bit resolves at H+1, return to IDLE immediately, without waiting for the wrap. This absorbs baud mismatch.
- Frame completion (cycle after the final stop-bit resolve), priority highest first:
  1. Any stop bit low -> frame_err pulse.
  2. Else parity bad -> parity_err pulse.
  3. Else if rx_valid && !rx_ready -> overrun pulse; rx_data and rx_valid are unchanged.
  4. Else rx_data is loaded and rx_valid=1.
  - Only one error pulse per frame.
- Latency: rx_valid rises 1 clock after the final stop-bit resolve point.
- Handshake:
  - rx_valid stays high and rx_data is stable until a cycle with rx_ready=1; rx_valid clears on the following edge.
  - If acceptance and a new good frame completion occur in the same cycle, rx_data takes the new word, rx_valid stays 1, and there is no overrun.
- Line held low (break): START passes, data is all 0, the stop bit is low -> frame_err. The FSM then returns to IDLE and re-enters START immediately while the line stays low. Expect a frame_err roughly every frame time; no lockup.
- busy is high in START, DATA, PARITY and STOP.
- Asynchronous reset mid-frame aborts the frame. The partial frame is discarded and no pulse is produced.

Optional Feature:
UART_RX_CMD_EN:
- Defined: work and enc ports exist. Each accepted good word, decoded on its lower 8 bits, updates them on the same edge that rx_valid is set:
  - "W" -> work=1
  - "S" -> work=0
  - "E" -> enc=1
  - "D" -> enc=0
  - any other value -> no change
- Decoding happens at the completion event and is independent of rx_ready. Errored and overrun words are not decoded.
- Not defined: the work and enc ports and the decoder are absent; all other behaviour is identical.

Test Plan:
1. Defaults (BPS_CNT=434). Send 0x57 as 8N1, with rx_ready held at 0 -> rx_valid=1 and rx_data=0x57, exactly 1 clock after the stop-bit resolve; no error pulses. Assert rx_ready -> rx_valid drops on the next edge. With UART_RX_CMD_EN, work goes 0->1.
2. PARITY_MODE=2 (even). Send 0x03 with parity bit 1 -> parity_err pulses once, rx_valid stays 0. Then send 0x03 with parity bit 0 -> rx_valid=1, rx_data=0x03.
3. Drive uart_rxd low for 100 clocks, then high -> busy pulses, the START state rejects it, and there is no rx_valid and no error pulse.
4. Send 0x41 with the stop bit driven low -> frame_err pulses once, rx_data is unchanged, and the FSM is back in IDLE before the next frame. A following 0x42 is received correctly.
5. rx_ready=0. Send 0x11, then 0x22 -> the first gives rx_valid=1 with rx_data=0x11; the second pulses overrun, and rx_data is still 0x11.
6. Assert rst_n low at mid-DATA of frame 0x5A. After release, send 0x33 -> rx_data=0x33 only, with no spurious valid or error. With UART_RX_CMD_EN, work=0 and enc=1 after reset.
